// File: rtl/packet_drop_queue.sv
// packet_drop_queue
//   Packet-aware beat FIFO. Beats of a packet are written speculatively past
//   the commit pointer and only become visible to the reader when the final
//   beat arrives and the packet's byte count is pushed into a companion size
//   queue. Packets that overflow the data store, exceed max_pkt_els_p beats,
//   are interrupted by a new start, or find the size queue full are dumped.
//
//   Optional feature macro: PACKET_DROP_QUEUE_STATS_EN
//     defined   -> drop_cnt / cmt_cnt are saturating 32-bit event counters
//     undefined -> drop_cnt / cmt_cnt are tied to zero, no counter flops
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_req, wr_data     beat offered / beat payload
//   wr_start, wr_end    first / last beat markers
//   wr_padbytes         unused bytes in the last beat
//   full                data store full
//   rd_req, rd_data     pop head beat / head beat (first-word fall-through)
//   empty               no committed beat available
//   size_rd_req         pop head packet size
//   size_rd_data        head packet byte count (fall-through)
//   size_empty          no size entry available
//   drop_cnt, cmt_cnt   packets dropped / committed

module packet_drop_queue #(
    parameter int data_width_p  = 512,
    parameter int log2_els_p    = 4,
    parameter int max_pkt_els_p = 16,
    localparam int PAD_W  = $clog2(data_width_p / 8),
    localparam int SIZE_W = log2_els_p + PAD_W + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_req,
    input  logic [data_width_p-1:0] wr_data,
    input  logic                    wr_start,
    input  logic                    wr_end,
    input  logic [PAD_W-1:0]        wr_padbytes,
    output logic                    full,
    input  logic                    rd_req,
    output logic [data_width_p-1:0] rd_data,
    output logic                    empty,
    input  logic                    size_rd_req,
    output logic [SIZE_W-1:0]       size_rd_data,
    output logic                    size_empty,
    output logic [31:0]             drop_cnt,
    output logic [31:0]             cmt_cnt
);

    localparam int DEPTH = 2 ** log2_els_p;
    localparam int AW    = log2_els_p;
    localparam int PTR_W = log2_els_p + 1;
    localparam int CNT_W = log2_els_p + 1;

    typedef enum logic [1:0] {READY, WRITING, PASS} state_t;

    state_t             state, state_n;
    logic [PTR_W-1:0]   wr_ptr, cmt_ptr, rd_ptr;
    logic [PTR_W-1:0]   wr_ptr_n, cmt_ptr_n;
    logic [CNT_W-1:0]   els, els_n, pkt_els;
    logic [PTR_W-1:0]   sq_wr, sq_rd;
    logic [PTR_W-1:0]   data_used, sq_used;
    logic               sq_full;
    logic               mem_we, push;
    logic [AW-1:0]      mem_waddr;
    logic [SIZE_W-1:0]  push_size;
    logic [1:0]         drop_inc;
    logic               cmt_inc;

    logic [data_width_p-1:0] mem    [DEPTH];
    logic [SIZE_W-1:0]       sq_mem [DEPTH];

    // Status flags come from registered pointers only, so a read in the
    // current cycle frees space for the writer one cycle later.
    assign data_used  = wr_ptr - rd_ptr;
    assign sq_used    = sq_wr - sq_rd;
    assign full       = (data_used == PTR_W'(DEPTH));
    assign empty      = (rd_ptr == cmt_ptr);
    assign sq_full    = (sq_used == PTR_W'(DEPTH));
    assign size_empty = (sq_wr == sq_rd);

    assign rd_data      = mem[rd_ptr[AW-1:0]];
    assign size_rd_data = sq_mem[sq_rd[AW-1:0]];

    assign push_size = (SIZE_W'(pkt_els) << PAD_W) - SIZE_W'(wr_padbytes);

    always_comb begin
        state_n   = state;
        wr_ptr_n  = wr_ptr;
        cmt_ptr_n = cmt_ptr;
        els_n     = els;
        pkt_els   = '0;
        mem_we    = 1'b0;
        mem_waddr = wr_ptr[AW-1:0];
        push      = 1'b0;
        drop_inc  = 2'd0;
        cmt_inc   = 1'b0;
        if (wr_req) begin
            case (state)
                READY, PASS: begin
                    // No packet is open here, so wr_ptr == cmt_ptr.
                    if (wr_start) begin
                        if (full) begin
                            drop_inc = 2'd1;
                            state_n  = wr_end ? READY : PASS;
                        end else begin
                            mem_we = 1'b1;
                            if (wr_end) begin
                                state_n = READY;
                                if (sq_full) begin
                                    drop_inc = 2'd1;
                                end else begin
                                    cmt_ptr_n = wr_ptr + PTR_W'(1);
                                    wr_ptr_n  = wr_ptr + PTR_W'(1);
                                    pkt_els   = CNT_W'(1);
                                    push      = 1'b1;
                                    cmt_inc   = 1'b1;
                                end
                            end else begin
                                wr_ptr_n = wr_ptr + PTR_W'(1);
                                els_n    = CNT_W'(1);
                                state_n  = WRITING;
                            end
                        end
                    end else if (state == PASS && wr_end) begin
                        state_n = READY;
                    end
                end
                WRITING: begin
                    if (full) begin
                        drop_inc = 2'd1;
                        wr_ptr_n = cmt_ptr;
                        els_n    = '0;
                        state_n  = wr_end ? READY : PASS;
                    end else if (wr_start) begin
                        // Abandon the open packet and restart at cmt_ptr; a
                        // full size queue on a single-beat restart drops both.
                        drop_inc  = 2'd1;
                        mem_we    = 1'b1;
                        mem_waddr = cmt_ptr[AW-1:0];
                        if (wr_end) begin
                            state_n = READY;
                            els_n   = '0;
                            if (sq_full) begin
                                drop_inc = 2'd2;
                                wr_ptr_n = cmt_ptr;
                            end else begin
                                cmt_ptr_n = cmt_ptr + PTR_W'(1);
                                wr_ptr_n  = cmt_ptr + PTR_W'(1);
                                pkt_els   = CNT_W'(1);
                                push      = 1'b1;
                                cmt_inc   = 1'b1;
                            end
                        end else begin
                            wr_ptr_n = cmt_ptr + PTR_W'(1);
                            els_n    = CNT_W'(1);
                        end
                    end else if (els == CNT_W'(max_pkt_els_p)) begin
                        drop_inc = 2'd1;
                        wr_ptr_n = cmt_ptr;
                        els_n    = '0;
                        state_n  = wr_end ? READY : PASS;
                    end else begin
                        mem_we = 1'b1;
                        if (wr_end) begin
                            state_n = READY;
                            els_n   = '0;
                            if (sq_full) begin
                                drop_inc = 2'd1;
                                wr_ptr_n = cmt_ptr;
                            end else begin
                                cmt_ptr_n = wr_ptr + PTR_W'(1);
                                wr_ptr_n  = wr_ptr + PTR_W'(1);
                                pkt_els   = els + CNT_W'(1);
                                push      = 1'b1;
                                cmt_inc   = 1'b1;
                            end
                        end else begin
                            wr_ptr_n = wr_ptr + PTR_W'(1);
                            els_n    = els + CNT_W'(1);
                        end
                    end
                end
                default: state_n = READY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= READY;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            cmt_ptr <= '0;
            rd_ptr  <= '0;
            els     <= '0;
            sq_wr   <= '0;
            sq_rd   <= '0;
        end else begin
            wr_ptr  <= wr_ptr_n;
            cmt_ptr <= cmt_ptr_n;
            els     <= els_n;
            if (rd_req && !empty)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push)
                sq_wr <= sq_wr + PTR_W'(1);
            if (size_rd_req && !size_empty)
                sq_rd <= sq_rd + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= wr_data;
        if (push)
            sq_mem[sq_wr[AW-1:0]] <= push_size;
    end

`ifdef PACKET_DROP_QUEUE_STATS_EN
    logic [31:0] drop_q, cmt_q;

    function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [1:0] inc);
        logic [32:0] s;
        s = {1'b0, v} + {31'b0, inc};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
            cmt_q  <= '0;
        end else begin
            drop_q <= sat_add(drop_q, drop_inc);
            cmt_q  <= sat_add(cmt_q, {1'b0, cmt_inc});
        end
    end

    assign drop_cnt = drop_q;
    assign cmt_cnt  = cmt_q;
`else
    logic unused_stats;
    assign unused_stats = ^{drop_inc, cmt_inc};
    assign drop_cnt     = '0;
    assign cmt_cnt      = '0;
`endif

endmodule
